// File: rtl/hist_peak_finder_if.sv
// Bin-stream / peak-result bundle for hist_peak_finder.
//   master : histogram builder side (drives bins + thresh, consumes results)
//   slave  : peak finder side (accepts bins, drives results)
// Signals:
//   binValid/binReady : beat handshake
//   binCount/binLast  : bin count and end-of-frame marker
//   hisNumIn          : histogram id, meaningful on a frame's first beat
//   thresh            : minimum peak count, sampled on the end beat
//   peakValid         : one-cycle result strobe
//   peakBin/peakCount/leftCount/rightCount/noPeak/hisNumOut : frame result
interface hist_peak_finder_if #(
  parameter int NB    = 6,
  parameter int CNT_W = 8
);
  logic             binValid;
  logic             binReady;
  logic [CNT_W-1:0] binCount;
  logic             binLast;
  logic             hisNumIn;
  logic [CNT_W-1:0] thresh;
  logic             peakValid;
  logic [NB-1:0]    peakBin;
  logic [CNT_W-1:0] peakCount;
  logic [CNT_W-1:0] leftCount;
  logic [CNT_W-1:0] rightCount;
  logic             noPeak;
  logic             hisNumOut;

  modport master (
    output binValid, binCount, binLast, hisNumIn, thresh,
    input  binReady, peakValid, peakBin, peakCount, leftCount, rightCount,
           noPeak, hisNumOut
  );

  modport slave (
    input  binValid, binCount, binLast, hisNumIn, thresh,
    output binReady, peakValid, peakBin, peakCount, leftCount, rightCount,
           noPeak, hisNumOut
  );
endinterface

// File: rtl/hist_peak_finder.sv
// Histogram peak finder. Consumes one frame of bin counts (one bin per beat),
// tracks the strictly-greatest bin (ties keep the earliest), and on the end
// beat reports the peak index/count plus both neighbour counts for sub-bin
// interpolation downstream. A frame ends on binLast or on bin BIN_NUM-1.
// Ports:
//   clk : rising-edge clock
//   res : synchronous active-high reset
//   bus : hist_peak_finder_if.slave (bin stream in, peak result out)
module hist_peak_finder #(
  parameter int NB      = 6,
  parameter int BIN_NUM = 64,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                res,
  hist_peak_finder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t           state;
  logic [NB-1:0]    idx;        // index expected for the next SCAN beat
  logic [NB-1:0]    max_idx;
  logic [CNT_W-1:0] max_cnt;
  logic [CNT_W-1:0] left_cnt;
  logic [CNT_W-1:0] right_cnt;
  logic [CNT_W-1:0] prev_cnt;
  logic             right_pend; // peak's right neighbour not yet seen
  logic             his_q;

  logic             acc;
  logic             first;
  logic             last;
  logic [NB-1:0]    cur_idx;
  logic [NB-1:0]    max_idx_n;
  logic [CNT_W-1:0] max_n, left_n, right_n;
  logic             rp_n, his_n;

  assign bus.binReady = (state != REPORT);
  assign acc          = bus.binValid & bus.binReady;
  assign first        = (state == IDLE);
  assign cur_idx      = first ? '0 : idx;
  assign last         = bus.binLast | (cur_idx == NB'(BIN_NUM - 1));
  assign his_n        = first ? bus.hisNumIn : his_q;

  // Tracker update for the beat on the bus; a new maximum restarts the
  // neighbour capture, so it wins over a pending right capture.
  always_comb begin
    max_n     = max_cnt;
    max_idx_n = max_idx;
    left_n    = left_cnt;
    right_n   = right_cnt;
    rp_n      = right_pend;
    if (first) begin
      max_n     = bus.binCount;
      max_idx_n = '0;
      left_n    = '0;
      right_n   = '0;
      rp_n      = 1'b1;
    end else if (bus.binCount > max_cnt) begin
      max_n     = bus.binCount;
      max_idx_n = idx;
      left_n    = prev_cnt;
      rp_n      = 1'b1;
    end else if (right_pend) begin
      right_n   = bus.binCount;
      rp_n      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state          <= IDLE;
      idx            <= '0;
      max_idx        <= '0;
      max_cnt        <= '0;
      left_cnt       <= '0;
      right_cnt      <= '0;
      prev_cnt       <= '0;
      right_pend     <= 1'b0;
      his_q          <= 1'b0;
      bus.peakValid  <= 1'b0;
      bus.peakBin    <= '0;
      bus.peakCount  <= '0;
      bus.leftCount  <= '0;
      bus.rightCount <= '0;
      bus.noPeak     <= 1'b0;
      bus.hisNumOut  <= 1'b0;
    end else begin
      bus.peakValid <= 1'b0;
      case (state)
        IDLE, SCAN: begin
          if (acc) begin
            max_cnt    <= max_n;
            max_idx    <= max_idx_n;
            left_cnt   <= left_n;
            right_cnt  <= right_n;
            right_pend <= rp_n;
            prev_cnt   <= bus.binCount;
            his_q      <= his_n;
            idx        <= cur_idx + NB'(1);
            if (last) begin
              // Results include the end beat; an uncaptured right neighbour
              // means the peak sits on the last bin.
              state          <= REPORT;
              bus.peakValid  <= 1'b1;
              bus.peakBin    <= max_idx_n;
              bus.peakCount  <= max_n;
              bus.leftCount  <= left_n;
              bus.rightCount <= rp_n ? '0 : right_n;
              bus.noPeak     <= (max_n < bus.thresh);
              bus.hisNumOut  <= his_n;
            end else begin
              state <= SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_peak_finder.sv
module tb_hist_peak_finder;
  localparam int NB = 6, BIN_NUM = 64, CNT_W = 8;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  hist_peak_finder_if #(.NB(NB), .CNT_W(CNT_W)) bus ();

  hist_peak_finder #(.NB(NB), .BIN_NUM(BIN_NUM), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  typedef struct {
    int bin;
    int cnt;
    int left;
    int right;
    int nop;
    int his;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_end_cyc = -10;
  int   low_run = 0;
  bit   mon_en = 0;
  int   frame[BIN_NUM];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: scan the finished frame as a whole array.
  function automatic exp_t model(input int len, input int his, input int th);
    exp_t e;
    int   n, best;
    n    = (len > BIN_NUM) ? BIN_NUM : len;
    best = 0;
    for (int i = 1; i < n; i++) if (frame[i] > frame[best]) best = i;
    e.bin   = best;
    e.cnt   = frame[best];
    e.left  = (best > 0) ? frame[best-1] : 0;
    e.right = (best < n - 1) ? frame[best+1] : 0;
    e.nop   = (frame[best] < th) ? 1 : 0;
    e.his   = his;
    return e;
  endfunction

  // Drives len beats; stalls = number of random bubble cycles inside the frame.
  // Leaves binValid high on return so a following frame can chain directly.
  task automatic send_frame(input int len, input bit last_flag, input bit his,
                            input int th, input int stalls, input bit expect_res);
    bit [BIN_NUM-1:0] smask;
    int               placed;
    smask  = '0;
    placed = 0;
    while (placed < stalls && len > 1) begin
      int p;
      p = $urandom_range(len - 1, 1);
      if (!smask[p]) begin smask[p] = 1'b1; placed++; end
    end
    if (expect_res) sb.push_back(model(len, his, th));
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (smask[i]) begin
        bus.binValid = 1'b0;
        bus.binCount = 8'($urandom);
        bus.binLast  = 1'b1;
        @(negedge clk);
      end
      bus.binValid = 1'b1;
      bus.binCount = 8'(frame[i]);
      bus.binLast  = last_flag && (i == len - 1);
      bus.hisNumIn = (i == 0) ? his : ~his;
      bus.thresh   = (i == len - 1) ? 8'(th) : 8'($urandom);
      while (!bus.binReady) @(negedge clk);
      @(posedge clk);
      if (i == len - 1 && (last_flag || len == BIN_NUM)) last_end_cyc = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.binValid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < BIN_NUM; i++) frame[i] = v;
  endtask

  // Monitor: pops the scoreboard on every result strobe.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!res) begin
        if (bus.peakValid) begin
          if (sb.size() == 0) begin
            chk("unexpected_peakValid", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("peakBin", bus.peakBin, e.bin);
            chk("peakCount", bus.peakCount, e.cnt);
            chk("leftCount", bus.leftCount, e.left);
            chk("rightCount", bus.rightCount, e.right);
            chk("noPeak", bus.noPeak, e.nop);
            chk("hisNumOut", bus.hisNumOut, e.his);
            chk("latency", cyc, last_end_cyc);
          end
        end
        if (!bus.binReady) low_run++;
        else if (low_run != 0) begin
          chk("ready_low_cycles", low_run, 1);
          low_run = 0;
        end
      end
    end
  end

  initial begin
    bus.binValid = 1'b0;
    bus.binCount = '0;
    bus.binLast  = 1'b0;
    bus.hisNumIn = 1'b0;
    bus.thresh   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_peakValid", bus.peakValid, 0);
    chk("rst_peakBin", bus.peakBin, 0);
    chk("rst_peakCount", bus.peakCount, 0);
    chk("rst_left", bus.leftCount, 0);
    chk("rst_right", bus.rightCount, 0);
    chk("rst_noPeak", bus.noPeak, 0);
    chk("rst_hisNumOut", bus.hisNumOut, 0);
    chk("rst_binReady", bus.binReady, 1);
    @(negedge clk);
    res    = 1'b0;
    mon_en = 1'b1;

    // single peak
    fill(0); frame[19] = 5; frame[20] = 40; frame[21] = 7;
    send_frame(64, 1, 1, 10, 0, 1); idle(3);
    // tie keeps earliest bin
    fill(1); frame[0] = 30; frame[50] = 30;
    send_frame(64, 1, 0, 20, 0, 1); idle(3);
    // peak on last bin, frame ended by bin count alone
    fill(0); frame[62] = 4; frame[63] = 9;
    send_frame(64, 0, 1, 5, 0, 1); idle(3);
    // below threshold, then threshold 0
    fill(3);
    send_frame(64, 1, 0, 4, 0, 1); idle(2);
    send_frame(64, 1, 0, 0, 0, 1); idle(2);
    // short frames with stalls, back to back
    for (int i = 0; i < BIN_NUM; i++) frame[i] = $urandom_range(50);
    send_frame(10, 1, 1, 20, 3, 1);
    for (int i = 0; i < BIN_NUM; i++) frame[i] = $urandom_range(50);
    send_frame(12, 1, 0, 20, 2, 1); idle(3);
    // single-bin frame
    fill(0); frame[0] = 17;
    send_frame(1, 1, 1, 17, 0, 1); idle(2);
    // peak overtaken at its right neighbour
    fill(0); frame[10] = 20; frame[11] = 25; frame[12] = 3;
    send_frame(64, 1, 1, 1, 0, 1); idle(3);
    // reset mid-frame
    for (int i = 0; i < BIN_NUM; i++) frame[i] = $urandom_range(100, 1);
    send_frame(30, 0, 0, 1, 0, 0);
    @(negedge clk);
    bus.binValid = 1'b0;
    res = 1'b1;
    @(posedge clk);
    #1;
    chk("inrst_peakValid", bus.peakValid, 0);
    chk("inrst_peakBin", bus.peakBin, 0);
    chk("inrst_peakCount", bus.peakCount, 0);
    chk("inrst_left", bus.leftCount, 0);
    chk("inrst_right", bus.rightCount, 0);
    chk("inrst_noPeak", bus.noPeak, 0);
    chk("inrst_hisNumOut", bus.hisNumOut, 0);
    chk("inrst_binReady", bus.binReady, 1);
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < BIN_NUM; i++) frame[i] = $urandom_range(199);
    frame[5] = 200;
    send_frame(64, 1, 1, 100, 0, 1); idle(3);

    // random frames, optional chaining
    for (int f = 0; f < 30; f++) begin
      int len;
      bit lf;
      len = $urandom_range(BIN_NUM, 1);
      lf  = (len < BIN_NUM) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < BIN_NUM; i++)
        frame[i] = (f % 2) ? $urandom_range(255) : $urandom_range(6);
      send_frame(len, lf, 1'($urandom), $urandom_range((f % 2) ? 255 : 7),
                 $urandom_range((len > 5) ? 5 : len - 1), 1);
      if ($urandom_range(1)) idle($urandom_range(3, 1));
    end
    idle(3);

    for (int w = 0; w < 200 && sb.size() != 0; w++) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
